ltc2308_scan_ctrl: RTL

//  Sequencer for the on-board LTC2308 8-channel 12-bit SPI ADC (adc_convst/adc_sck/adc_sdi/adc_sdo).

---
 rtl/ltc2308_scan_ctrl.sv | 105 ++++++++++
 1 files changed

// File: rtl/ltc2308_scan_ctrl.sv
// ltc2308_scan_ctrl: round-robin LTC2308 scan sequencer with one-frame config/result pipelining
module ltc2308_scan_ctrl #(
   parameter int CONVST_CYCLES = 2,
   parameter int CONV_CYCLES   = 80,
   parameter int SCK_HALF      = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        enable,
   input  logic [7:0]  ch_mask,
   input  logic        uni,
   output logic        busy,
   output logic        result_valid,
   output logic [2:0]  result_ch,
   output logic [11:0] result_data,
   output logic        adc_convst,
   output logic        adc_sck,
   output logic        adc_sdi,
   input  logic        adc_sdo
);
   typedef enum logic [2:0] {IDLE, CONVST, CONV, SHIFT, DONE} state_t;
   state_t      state, state_nx;
   logic [15:0] cnt;
   logic        phase;
   logic [3:0]  bit_idx;
   logic [2:0]  cfg_ch, prev_ch;
   logic        primed, uni_q;
   logic [11:0] shreg;
   logic [15:0] sdi_word;
   logic        half_end, run;
   // next set mask bit above c, wrapping; offset 8 lands back on c so a single-bit mask repeats
   function automatic logic [2:0] next_ch(input logic [7:0] m, input logic [2:0] c);
      logic [2:0] n;
      next_ch = c;
      for (int i = 8; i >= 1; i--) begin
         n = c + 3'(i);
         if (m[n]) next_ch = n;
      end
   endfunction
   assign half_end   = cnt == 16'(SCK_HALF - 1);
   assign run        = enable && |ch_mask;
   assign sdi_word   = {10'd0, uni_q, cfg_ch[1], cfg_ch[2], cfg_ch[0], 1'b1};
   assign busy       = state != IDLE;
   assign adc_convst = state == CONVST;
   assign adc_sck    = state == SHIFT && phase;
   assign adc_sdi    = state == SHIFT && sdi_word[bit_idx];
   // state register
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) state <= IDLE;
      else state <= state_nx;
   // next-state logic
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = run ? CONVST : IDLE;
         CONVST:  state_nx = cnt == 16'(CONVST_CYCLES - 1) ? CONV : CONVST;
         CONV:    state_nx = cnt == 16'(CONV_CYCLES - 1) ? SHIFT : CONV;
         SHIFT:   state_nx = phase && half_end && bit_idx == 4'd11 ? DONE : SHIFT;
         DONE:    state_nx = run ? CONVST : IDLE;
         default: state_nx = IDLE;
      endcase
   end
   // timing counters, SPI shifting, channel rotation and result publication
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         cnt          <= '0;
         phase        <= 1'b0;
         bit_idx      <= '0;
         cfg_ch       <= '0;
         prev_ch      <= '0;
         primed       <= 1'b0;
         uni_q        <= 1'b0;
         shreg        <= '0;
         result_valid <= 1'b0;
         result_ch    <= '0;
         result_data  <= '0;
      end else begin
         result_valid <= 1'b0;
         if (state == SHIFT) begin
            cnt <= half_end ? '0 : cnt + 16'd1;
            if (half_end) phase <= ~phase;
            if (half_end && phase) bit_idx <= bit_idx + 4'd1;
            if (phase && cnt == '0) shreg <= {shreg[10:0], adc_sdo};
         end else begin
            cnt     <= (state_nx != state || state == IDLE) ? '0 : cnt + 16'd1;
            phase   <= 1'b0;
            bit_idx <= '0;
         end
         if (state == CONVST) uni_q <= uni;
         if (state == IDLE) begin
            primed <= 1'b0;
            if (run) cfg_ch <= next_ch(ch_mask, 3'd7);
         end
         if (state == DONE) begin
            result_valid <= primed;
            if (primed) begin
               result_ch   <= prev_ch;
               result_data <= shreg;
            end
            prev_ch <= cfg_ch;
            primed  <= 1'b1;
            cfg_ch  <= next_ch(ch_mask, cfg_ch);
         end
      end
endmodule
